// File: rtl/vector_alu_pkg.sv
// Shared definitions for the vector ALU: opcode encoding, flag bit positions
// and saturation limits.
package vector_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MV  = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8,
        OP_SLL = 4'd9,
        OP_SRA = 4'd10
    } op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_W = 4;

    // Saturation limits for a w-bit two's-complement lane, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/vector_alu_lane.sv
// One combinational ALU lane: result and {N,C,V,Z} flags for a single operand pair.
module vector_alu_lane
    import vector_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            oper,
    input  logic                  sat,
    output logic [DATA_WIDTH-1:0] res,
    output logic [FLAG_W-1:0]     flags,
    output logic                  err
);

    localparam int SH = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MINV = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic [SH-1:0]         amt;
    logic [SH:0]           amt_inv;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH:0]   sll_ext;
    logic [DATA_WIDTH-1:0] rol_res;
    logic [DATA_WIDTH-1:0] ror_res;
    logic [DATA_WIDTH-1:0] sra_res;
    logic [DATA_WIDTH-1:0] raw;
    logic                  c;
    logic                  v;

    assign amt     = b[SH-1:0];
    assign amt_inv = (SH+1)'(DATA_WIDTH) - {1'b0, amt};
    assign sum     = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the unsigned borrow.
    assign diff    = {1'b0, a} - {1'b0, b};
    assign sll_ext = {1'b0, a} << amt;
    assign rol_res = (a << amt) | (a >> amt_inv);
    assign ror_res = (a >> amt) | (a << amt_inv);
    assign sra_res = $signed(a) >>> amt;

    always_comb begin
        raw = '0;
        c   = 1'b0;
        v   = 1'b0;
        err = 1'b0;
        case (oper)
            OP_ADD: begin
                raw = sum[DATA_WIDTH-1:0];
                c   = sum[DATA_WIDTH];
                v   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                raw = diff[DATA_WIDTH-1:0];
                c   = diff[DATA_WIDTH];
                v   = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_AND: raw = a & b;
            OP_OR:  raw = a | b;
            OP_XOR: raw = a ^ b;
            OP_MV:  raw = a;
            OP_ROL: raw = rol_res;
            OP_ROR: raw = ror_res;
            OP_SLL: begin
                raw = sll_ext[DATA_WIDTH-1:0];
                c   = sll_ext[DATA_WIDTH];
            end
            OP_SRA: raw = sra_res;
            default: err = 1'b1;
        endcase

        // Overflow on ADD/SUB always has the direction given by operand a's sign.
        res = raw;
        if ((oper == OP_ADD || oper == OP_SUB) && sat && v)
            res = a[DATA_WIDTH-1] ? MINV : MAXV;

        flags         = '0;
        flags[FLAG_N] = res[DATA_WIDTH-1];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
        flags[FLAG_Z] = (res == '0);
    end

endmodule

// File: rtl/vector_alu_lanes.sv
// SIMD ALU: LANES parallel lanes computed at accept time, followed by an
// elastic register pipeline of PIPE_DEPTH stages.
module vector_alu_lanes
    import vector_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [LANES*DATA_WIDTH-1:0]  t0_data,
    input  logic [LANES*DATA_WIDTH-1:0]  t1_data,
    input  logic [3:0]                   t_oper,
    input  logic                         t_sat,
    input  logic                         t_valid,
    output logic                         t_ready,
    output logic [LANES*DATA_WIDTH-1:0]  i_data,
    output logic [LANES*FLAG_W-1:0]      i_flags,
    output logic                         i_err,
    output logic                         i_valid,
    input  logic                         i_ready
);

    localparam int DW = LANES * DATA_WIDTH;
    localparam int FW = LANES * FLAG_W;

    // Handshake: a beat moves across an interface on a clock edge where valid
    // and ready are both high; a stage holds its payload unchanged otherwise.
    logic [DW-1:0]         lane_res;
    logic [FW-1:0]         lane_flags;
    logic [LANES-1:0]      lane_err;

    logic [PIPE_DEPTH-1:0] st_valid;
    logic [DW-1:0]         st_data  [PIPE_DEPTH];
    logic [FW-1:0]         st_flags [PIPE_DEPTH];
    logic                  st_err   [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] adv;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vector_alu_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .a     (t0_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .b     (t1_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .oper  (t_oper),
            .sat   (t_sat),
            .res   (lane_res[k*DATA_WIDTH +: DATA_WIDTH]),
            .flags (lane_flags[k*FLAG_W +: FLAG_W]),
            .err   (lane_err[k])
        );
    end

    // Stage k may advance if downstream is ready or any stage from k onward is empty.
    always_comb begin : p_adv
        logic room;
        room = 1'b0;
        adv  = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            room = i_ready;
            for (int j = k; j < PIPE_DEPTH; j++)
                room = room | ~st_valid[j];
            adv[k] = room;
        end
    end

    assign t_ready = adv[0] & ~srst;

    always_ff @(posedge clk) begin
        if (srst) begin
            st_valid <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                st_data[k]  <= '0;
                st_flags[k] <= '0;
                st_err[k]   <= 1'b0;
            end
        end else begin
            if (adv[0]) begin
                st_valid[0] <= t_valid;
                st_data[0]  <= lane_res;
                st_flags[0] <= lane_flags;
                st_err[0]   <= |lane_err;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (adv[k]) begin
                    st_valid[k] <= st_valid[k-1];
                    st_data[k]  <= st_data[k-1];
                    st_flags[k] <= st_flags[k-1];
                    st_err[k]   <= st_err[k-1];
                end
            end
        end
    end

    assign i_valid = st_valid[PIPE_DEPTH-1];
    assign i_data  = st_data[PIPE_DEPTH-1];
    assign i_flags = st_flags[PIPE_DEPTH-1];
    assign i_err   = st_err[PIPE_DEPTH-1];

endmodule

// File: tb/tb_vector_alu_lanes.sv
// Bench for vector_alu_lanes: directed vectors through a lane-level arithmetic
// model, a per-cycle output scoreboard, back-pressure and mid-flight reset.
module tb_vector_alu_lanes;
    import vector_alu_pkg::*;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int D  = 3;
    localparam int DW = L * W;
    localparam int FW = L * 4;
    localparam int EW = DW + FW + 1;

    logic          clk;
    logic          srst;
    logic [DW-1:0] t0_data;
    logic [DW-1:0] t1_data;
    logic [3:0]    t_oper;
    logic          t_sat;
    logic          t_valid;
    logic          t_ready;
    logic [DW-1:0] i_data;
    logic [FW-1:0] i_flags;
    logic          i_err;
    logic          i_valid;
    logic          i_ready;

    vector_alu_lanes #(
        .DATA_WIDTH(W),
        .LANES     (L),
        .PIPE_DEPTH(D)
    ) dut (
        .clk     (clk),
        .srst    (srst),
        .t0_data (t0_data),
        .t1_data (t1_data),
        .t_oper  (t_oper),
        .t_sat   (t_sat),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .i_data  (i_data),
        .i_flags (i_flags),
        .i_err   (i_err),
        .i_valid (i_valid),
        .i_ready (i_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] head;
    int            ready_mode   = 1;   // 0 hold low, 1 always high, 2 random
    int            out_count    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of one lane from the arithmetic definitions: returns {err, N, C, V, Z, result}.
    function automatic logic [20:0] model_lane(input logic [15:0] a, input logic [15:0] b,
                                               input logic [3:0] op, input logic sat);
        longint ua, ub, sa, sb, r, s;
        int     amt;
        logic   c, v, err;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        amt = int'(b[3:0]);
        c = 1'b0; v = 1'b0; err = 1'b0; r = 0; s = 0;
        case (op)
            4'd1: begin
                r = ua + ub; s = sa + sb;
                c = (r > 65535);
                v = (s > 32767) || (s < -32768);
                if (sat && v) r = (s > 0) ? 32767 : 32768;
            end
            4'd2: begin
                r = ua - ub; s = sa - sb;
                c = (ua < ub);
                v = (s > 32767) || (s < -32768);
                if (sat && v) r = (s > 0) ? 32767 : 32768;
            end
            4'd3:  r = ua & ub;
            4'd4:  r = ua | ub;
            4'd5:  r = ua ^ ub;
            4'd6:  r = ua;
            4'd7:  r = (ua << amt) | (ua >> (16 - amt));
            4'd8:  r = (ua >> amt) | (ua << (16 - amt));
            4'd9:  begin r = ua << amt; c = ((r >> 16) & 1) == 1; end
            4'd10: r = sa >>> amt;
            default: err = 1'b1;
        endcase
        r = r & 65535;
        return {err, r[15], c, v, (r == 0), r[15:0]};
    endfunction

    function automatic logic [EW-1:0] model_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [3:0] op, input logic sat);
        logic [DW-1:0] d;
        logic [FW-1:0] f;
        logic          e;
        logic [20:0]   m;
        e = 1'b0;
        for (int k = 0; k < L; k++) begin
            m = model_lane(a[k*W +: W], b[k*W +: W], op, sat);
            d[k*W +: W] = m[15:0];
            f[k*4 +: 4] = m[19:16];
            e = m[20];
        end
        return {e, f, d};
    endfunction

    // driver
    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [3:0] op, input logic sat);
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            #1;
            t0_data = a; t1_data = b; t_oper = op; t_sat = sat; t_valid = 1'b1;
            #1;
            if (t_ready) begin
                exp_q.push_back(model_beat(a, b, op, sat));
                done = 1;
                @(posedge clk);
                #1;
                t_valid = 1'b0;
            end
        end
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout: beat op %0d never accepted", op);
            t_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() > 0; n++) @(negedge clk);
        tests_run++;
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
        end
    endtask

    // scoreboard: every cycle with i_valid must show the oldest pending beat
    always @(negedge clk) begin
        if (!srst && i_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL unexpected_beat: got data %0h, no beat pending", i_data);
            end else begin
                head = exp_q[0];
                check("out_data", i_data, head[DW-1:0]);
                check("out_flags", i_flags, head[DW +: FW]);
                check("out_err", i_err, head[EW-1]);
            end
        end
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
        if (!srst && i_valid && i_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            out_count++;
        end
    end

    logic [DW-1:0] va [16];
    logic [DW-1:0] vb [16];
    logic [3:0]    vop[16];
    logic          vsat[16];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int base;
        logic [20:0] m;

        i_ready = 1'b0;
        srst    = 1'b1;
        t_valid = 1'b1;
        t0_data = {4{16'h0101}};
        t1_data = {4{16'h0202}};
        t_oper  = 4'd1;
        t_sat   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_t_ready", t_ready, 0);
        check("reset_i_valid", i_valid, 0);
        check("reset_i_data", i_data, 0);
        check("reset_i_flags", i_flags, 0);
        check("reset_i_err", i_err, 0);
        t_valid = 1'b0;
        srst    = 1'b0;
        #1;
        check("release_t_ready", t_ready, 1);

        // hand-computed anchors for the model
        m = model_lane(16'h7FFF, 16'h0001, OP_ADD, 1'b0); check("pin_add", m, {1'b0, 4'b1010, 16'h8000});
        m = model_lane(16'h7FFF, 16'h0001, OP_ADD, 1'b1); check("pin_add_sat", m, {1'b0, 4'b0010, 16'h7FFF});
        m = model_lane(16'h0000, 16'h0001, OP_SUB, 1'b0); check("pin_sub_borrow", m, {1'b0, 4'b1100, 16'hFFFF});
        m = model_lane(16'h1234, 16'h1234, OP_SUB, 1'b0); check("pin_sub_zero", m, {1'b0, 4'b0001, 16'h0000});
        m = model_lane(16'h8001, 16'h0001, OP_ROL, 1'b0); check("pin_rol", m, {1'b0, 4'b0000, 16'h0003});
        m = model_lane(16'h0001, 16'h0004, OP_ROR, 1'b0); check("pin_ror", m, {1'b0, 4'b0000, 16'h1000});
        m = model_lane(16'h8000, 16'h000F, OP_SRA, 1'b0); check("pin_sra", m, {1'b0, 4'b1000, 16'hFFFF});
        m = model_lane(16'h8000, 16'h0001, OP_SLL, 1'b0); check("pin_sll", m, {1'b0, 4'b0101, 16'h0000});
        m = model_lane(16'h5555, 16'h1111, 4'd0, 1'b0);   check("pin_illegal", m, {1'b1, 4'b0001, 16'h0000});

        // latency on an empty pipeline
        send_beat({16'h0004, 16'h0003, 16'h0002, 16'h0001}, '0, OP_MV, 1'b0);
        n = 0;
        while (!i_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, D);
        drain();

        // directed vectors; lane 0 holds the headline case of each row
        va[0]  = {16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF}; vb[0]  = {16'h4321, 16'h0001, 16'h8000, 16'h0001}; vop[0]  = OP_ADD; vsat[0]  = 0;
        va[1]  = va[0];                                    vb[1]  = vb[0];                                    vop[1]  = OP_ADD; vsat[1]  = 1;
        va[2]  = {16'h8000, 16'h7FFF, 16'h1234, 16'h0000}; vb[2]  = {16'h0001, 16'hFFFF, 16'h1234, 16'h0001}; vop[2]  = OP_SUB; vsat[2]  = 0;
        va[3]  = va[2];                                    vb[3]  = vb[2];                                    vop[3]  = OP_SUB; vsat[3]  = 1;
        va[4]  = {16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h1234}; vb[4]  = {16'h5A5A, 16'hFF00, 16'h8001, 16'h00FF}; vop[4]  = OP_AND; vsat[4]  = 0;
        va[5]  = va[4];                                    vb[5]  = vb[4];                                    vop[5]  = OP_OR;  vsat[5]  = 0;
        va[6]  = va[4];                                    vb[6]  = vb[4];                                    vop[6]  = OP_XOR; vsat[6]  = 1;
        va[7]  = va[4];                                    vb[7]  = vb[4];                                    vop[7]  = OP_MV;  vsat[7]  = 0;
        va[8]  = {16'h8001, 16'hC003, 16'h1234, 16'h8001}; vb[8]  = {16'h0011, 16'h000F, 16'h0000, 16'h0001}; vop[8]  = OP_ROL; vsat[8]  = 0;
        va[9]  = {16'hABCD, 16'h8000, 16'h00F0, 16'h0001}; vb[9]  = {16'h0008, 16'h000F, 16'h0000, 16'h0004}; vop[9]  = OP_ROR; vsat[9]  = 0;
        va[10] = {16'h7FFF, 16'h4000, 16'h8001, 16'h8000}; vb[10] = {16'h000F, 16'h0002, 16'h0000, 16'h000F}; vop[10] = OP_SRA; vsat[10] = 0;
        va[11] = {16'h4001, 16'h0001, 16'hFFFF, 16'h8000}; vb[11] = {16'h0002, 16'h0000, 16'h000F, 16'h0001}; vop[11] = OP_SLL; vsat[11] = 0;
        va[12] = {16'h1111, 16'h2222, 16'h3333, 16'h4444}; vb[12] = {16'h0001, 16'h0002, 16'h0003, 16'h0004}; vop[12] = 4'd0;   vsat[12] = 0;
        va[13] = va[12];                                   vb[13] = vb[12];                                   vop[13] = OP_ADD; vsat[13] = 0;
        va[14] = va[12];                                   vb[14] = vb[12];                                   vop[14] = 4'd15;  vsat[14] = 1;
        va[15] = va[12];                                   vb[15] = vb[12];                                   vop[15] = OP_SUB; vsat[15] = 0;
        for (int i = 0; i < 16; i++) send_beat(va[i], vb[i], vop[i], vsat[i]);
        drain();

        // back-pressure with sequential-count beats and random gaps
        ready_mode = 2;
        base = out_count;
        for (int i = 0; i < 20; i++) begin
            send_beat({16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)}, {4{16'h0001}}, OP_ADD, 1'b0);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        drain();
        ready_mode = 1;
        check("bp_count", out_count - base, 20);

        // reset with three beats held in the pipeline
        ready_mode = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) send_beat({4{16'(i + 16'h0100)}}, '0, OP_MV, 1'b0);
        @(negedge clk);
        #1;
        srst = 1'b1;
        exp_q.delete();
        base = out_count;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        srst = 1'b0;
        #1;
        check("post_reset_t_ready", t_ready, 1);
        check("post_reset_i_valid", i_valid, 0);
        ready_mode = 1;
        repeat (8) @(negedge clk);
        check("flushed_count", out_count - base, 0);
        send_beat({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}, {4{16'h0101}}, OP_XOR, 1'b0);
        drain();
        check("post_reset_out", out_count - base, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
